int_to_fp8_encoder: RTL and testbench

Sequential converter from 8-bit two's-complement integer to the team's 8-bit minifloat format: bit 7 sign, bits 6:3 exponent, bits 2:0 fraction, with a hidden leading 1. It produces the operands that the FP8 add datapath consumes. Normalisation uses one left shift per clock under a small FSM. A start/done handshake connects the block to the same controller style as the adder.

---
 rtl/int_to_fp8_encoder.sv | 143 ++++++++++++++
 tb/tb_int_to_fp8_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp8_encoder.sv
// int_to_fp8_encoder
// Converts an 8-bit two's-complement integer into the 8-bit minifloat used by
// the FP8 adder: {sign, exp[3:0], frac[2:0]} with a hidden leading one.
// The magnitude is normalised one left shift per clock. The 8-bit pattern is
// then rounded half-up on a single guard bit, so results agree with the adder.
//
// Handshake (start/done):
//   - start is sampled only while the FSM is in IDLE. in_int is captured on
//     that same edge and may change freely afterwards.
//   - busy is high while a conversion is in flight (NORM or ROUND). Any start
//     seen while busy is ignored.
//   - done is a one-cycle registered pulse. result is valid from that cycle
//     and is held until the next done.
//   - The FSM is already back in IDLE during the done cycle, so a start in
//     that cycle is accepted. Back-to-back conversions have no bubble.
//   - Asserting rst_n low aborts a conversion at once. No done follows, and
//     result returns to 8'h00.
module int_to_fp8_encoder #(
  parameter int BIAS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_int,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  // Exponent of a value whose leading one sits in bit 7 of the magnitude.
  localparam logic [3:0] EXP_INIT = 4'(BIAS + 7);

  state_t     state_q, state_d;
  logic       sign_q,  sign_d;
  logic [7:0] mag_q,   mag_d;
  logic [3:0] exp_q,   exp_d;
  logic       zero_q,  zero_d;
  logic [7:0] result_q, result_d;
  logic       done_q,  done_d;

  // Rounding terms. They are meaningful only in ROUND, once mag_q[7] is set.
  logic [4:0] rnd_sum;
  logic [3:0] mant_r;
  logic [3:0] exp_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round half-up on the guard bit. A carry out of the 4-bit mantissa
  // renormalises it to 1.000 and bumps the exponent.
  always_comb begin
    rnd_sum = {1'b0, 1'b1, mag_q[6:4]} + {4'b0000, mag_q[3]};
    mant_r  = rnd_sum[3:0];
    exp_r   = exp_q;
    if (rnd_sum[4]) begin
      mant_r = 4'b1000;
      exp_r  = exp_q + 4'd1;
    end
  end

  // Next-state and datapath update. Every register holds unless a state
  // says otherwise. done drops on any edge that does not leave ROUND.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    zero_d   = zero_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = in_int[7];
          // Negating -128 wraps back to 8'h80, which is its correct magnitude.
          mag_d   = in_int[7] ? (8'd0 - in_int) : in_int;
          exp_d   = EXP_INIT;
          zero_d  = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == 8'd0) begin
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else if (mag_q[7]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 4'd1;
        end
      end
      S_ROUND: begin
        // A zero input encodes as +0. The sign is dropped so -0 never appears.
        result_d = zero_q ? 8'h00 : {sign_q, exp_r, mant_r[2:0]};
        exp_d    = exp_r;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers, result and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      mag_q    <= 8'd0;
      exp_q    <= 4'd0;
      zero_q   <= 1'b0;
      result_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int_to_fp8_encoder.sv
// Bench for int_to_fp8_encoder. It covers directed cases, handshake corner
// cases, a reset abort, and a sweep of all 256 inputs checked against a
// reference model.
module tb_int_to_fp8_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_int = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [1:0] dbg_state;

  int_to_fp8_encoder #(.BIAS(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_int    (in_int),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Scoreboard state.
  logic [7:0] exp_q[$];
  int         cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  logic [7:0] mon_w;
  int         mon_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference model. It locates the leading one arithmetically, then scales the
  // magnitude into [16,32) so that bit 0 of the scaled value is the guard bit.
  function automatic logic [7:0] model(input logic [7:0] x, output int lat);
    int m;
    int p;
    int scaled;
    int mant;
    int e;
    logic [3:0] e4;
    logic [3:0] m4;
    m = x[7] ? (256 - int'(x)) : int'(x);
    if (m == 0) begin
      lat = 2;
      return 8'h00;
    end
    p = 7;
    while (((m >> p) & 1) == 0) p = p - 1;
    lat = (7 - p) + 2;
    scaled = (m << 4) >> p;
    mant = (scaled >> 1) + (scaled & 1);
    e = 7 + p;
    if (mant == 16) begin
      mant = 8;
      e = e + 1;
    end
    e4 = 4'(e);
    m4 = 4'(mant);
    return {x[7], e4, m4[2:0]};
  endfunction

  // Monitor: on every done, pop one entry and compare result and arrival cycle.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen = done_seen + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_w = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result", 32'(result), 32'(mon_w));
        check("latency", cyc, mon_c);
      end
    end
  end

  // Driver: raise start (at the next negedge, or at once if now=1).
  // The expectation is pushed right after the sampling edge.
  // The task returns at the following negedge, with cyc equal to the sampling edge.
  task automatic do_start(input logic [7:0] x, input logic [7:0] want, input int lat, input bit now);
    int e;
    if (!now) @(negedge clk);
    start  = 1'b1;
    in_int = x;
    @(posedge clk);
    #1;
    e = cyc;
    exp_q.push_back(want);
    cyc_q.push_back(e + lat);
    @(negedge clk);
    start  = 1'b0;
    in_int = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  int lat;
  logic [7:0] want;
  int snap;

  initial begin
    // Reset.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 5: busy for 7 cycles, done at E+7.
    do_start(8'd5, 8'h4A, 7, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("busy_profile", 32'(busy), (k < 7) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wait_idle();

    // Directed values from the test plan.
    do_start(8'hFD, 8'hC4, 8, 1'b0); wait_idle();
    do_start(8'd13, 8'h55, 6, 1'b0); wait_idle();
    do_start(8'd29, 8'h5F, 5, 1'b0); wait_idle();
    do_start(8'd127, 8'h70, 3, 1'b0); wait_idle();
    do_start(8'h80, 8'hF0, 2, 1'b0); wait_idle();
    do_start(8'h00, 8'h00, 2, 1'b0); wait_idle();

    // Start pulsed while busy must be ignored.
    do_start(8'd5, 8'h4A, 7, 1'b0);
    @(negedge clk);
    start = 1'b1; in_int = 8'd99;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // Start in the done cycle is accepted without a bubble.
    do_start(8'd13, 8'h55, 6, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    do_start(8'd29, 8'h5F, 5, 1'b1);
    wait_idle();

    // Reset abort two cycles into a conversion.
    do_start(8'd5, 8'h4A, 7, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'h00);
    check("abort_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    snap = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_seen - snap, 0);
    do_start(8'hFD, 8'hC4, 8, 1'b0);
    wait_idle();
    repeat (4) @(negedge clk);
    check("result_hold", 32'(result), 32'hC4);

    // Full input sweep against the model.
    for (int i = 0; i < 256; i++) begin
      want = model(8'(i), lat);
      do_start(8'(i), want, lat, 1'b0);
      wait_idle();
    end

    // Random back-to-back chain: each start lands in the previous done cycle.
    begin
      logic [7:0] x;
      x = 8'($urandom_range(0, 255));
      want = model(x, lat);
      do_start(x, want, lat, 1'b0);
      for (int n = 0; n < 30; n++) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (done) break;
        end
        x = 8'($urandom_range(0, 255));
        want = model(x, lat);
        do_start(x, want, lat, 1'b1);
      end
      wait_idle();
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
